// File: rtl/data_sram_resp_pkg.sv
// Shared constants and the byte-lane merge helper for the data SRAM responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package data_sram_resp_pkg;

  localparam logic [63:0] DATA_BASE_ADDR  = 64'h8000_0000;
  localparam int          DATA_SRAM_DEPTH = 4096;
  localparam int          DATA_IDX_W      = 12;

  // Lanes with be[k] set take new_w, the rest keep old_w.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  be);
    logic [63:0] res;
    res = old_w;
    for (int k = 0; k < 8; k++) begin
      if (be[k]) res[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_wbuf.sv
// One-entry byte-merging store buffer {valid, idx, be, data} with hit/bypass view.
// Latency: state updates at the clock edge; hit and bypass lanes are combinational.
// Backpressure: none; capture, merge and drain are accepted every cycle.
// Ports: capture_i/merge_i/drain_i controls, req_* store/lookup request,
//        valid_o/idx_o/be_o/data_o entry contents, hit_o/byp_be_o lookup result.
module data_sram_resp_wbuf
  import data_sram_resp_pkg::*;
#(
  parameter int IDX_W = DATA_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_i,
  input  logic             merge_i,
  input  logic             drain_i,
  input  logic [IDX_W-1:0] req_idx_i,
  input  logic [7:0]       req_be_i,
  input  logic [63:0]      req_data_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [7:0]       be_o,
  output logic [63:0]      data_o,
  output logic             hit_o,
  output logic [7:0]       byp_be_o
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       be_q, be_d;
  logic [63:0]      data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    be_d    = be_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = 1'b1;
      idx_d   = req_idx_i;
      be_d    = req_be_i;
      data_d  = req_data_i;
    end else if (merge_i) begin
      be_d   = be_q | req_be_i;
      data_d = byte_merge(data_q, req_data_i, req_be_i);
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Reset clears the entry so a pending store is dropped, never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      data_q  <= data_d;
    end
  end

  assign valid_o  = valid_q;
  assign idx_o    = idx_q;
  assign be_o     = be_q;
  assign data_o   = data_q;
  assign hit_o    = valid_q && (idx_q == req_idx_i);
  assign byp_be_o = hit_o ? be_q : 8'h00;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: single-port 64-bit word array behind a 1-entry store buffer.
// Latency: load data/rvalid and addr_err one cycle after the request.
// Backpressure: none; every request is accepted, stores never stall.
// Ports: clk, rst_n; data_sram_en/we/addr/wdata request; data_sram_rdata,
//        data_sram_rvalid load response; addr_err out-of-range pulse.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          DEPTH     = DATA_SRAM_DEPTH,
  parameter int          IDX_W     = DATA_IDX_W,
  parameter logic [63:0] BASE_ADDR = DATA_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_we,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        addr_err
);

  // Address decode
  logic [63:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             is_store;
  logic             ld_ok, ld_oor, st_ok, req_oor;

  assign off      = data_sram_addr - BASE_ADDR;
  assign in_range = (data_sram_addr >= BASE_ADDR) && (off[63:3] < 61'(DEPTH));
  assign idx      = off[IDX_W+2:3];
  assign is_store = |data_sram_we;
  assign ld_ok    = data_sram_en && !is_store && in_range;
  assign ld_oor   = data_sram_en && !is_store && !in_range;
  assign st_ok    = data_sram_en && is_store && in_range;
  assign req_oor  = data_sram_en && !in_range;

  logic unused_off;
  assign unused_off = ^off[2:0];

  // Store buffer
  logic             wb_valid, wb_hit;
  logic [IDX_W-1:0] wb_idx;
  logic [7:0]       wb_be, wb_byp_be;
  logic [63:0]      wb_data;
  logic             wb_capture, wb_merge, wb_drain;
  logic             mem_we;

  // The port is free for the buffer only when idle or when a store to a
  // different word evicts it; loads keep the port, so the entry stays put.
  assign wb_capture = st_ok && (!wb_valid || !wb_hit);
  assign wb_merge   = st_ok && wb_hit;
  assign wb_drain   = !data_sram_en && wb_valid;
  assign mem_we     = (st_ok && wb_valid && !wb_hit) || wb_drain;

  data_sram_resp_wbuf #(
    .IDX_W (IDX_W)
  ) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (wb_capture),
    .merge_i    (wb_merge),
    .drain_i    (wb_drain),
    .req_idx_i  (idx),
    .req_be_i   (data_sram_we),
    .req_data_i (data_sram_wdata),
    .valid_o    (wb_valid),
    .idx_o      (wb_idx),
    .be_o       (wb_be),
    .data_o     (wb_data),
    .hit_o      (wb_hit),
    .byp_be_o   (wb_byp_be)
  );

  // Array: contents are not reset. Read and write are mutually exclusive by
  // construction (read only on a load, write only on store/idle).
  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (wb_be[k]) mem_q[wb_idx][k*8 +: 8] <= wb_data[k*8 +: 8];
      end
    end
  end

  // Output registers
  logic [63:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ld_ok || ld_oor;
    err_d    = req_oor;
    if (ld_ok) begin
      rdata_d = byte_merge(mem_q[idx], wb_data, wb_byp_be);
    end else if (ld_oor) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign data_sram_rdata  = rdata_q;
  assign data_sram_rvalid = rvalid_q;
  assign addr_err         = err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: architectural memory model + response scoreboard.
// Latency: expects responses one cycle after each load / out-of-range request.
// Backpressure: none exercised; the DUT accepts a request every cycle.
module tb_data_sram_resp;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] LIM  = 64'h8000_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [7:0]  data_sram_we = 8'h00;
  logic [63:0] data_sram_addr = '0;
  logic [63:0] data_sram_wdata = '0;
  logic [63:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic        addr_err;

  always #5 clk = ~clk;

  data_sram_resp dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .addr_err         (addr_err)
  );

  typedef struct packed {
    logic        is_ld;
    logic [63:0] dat;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model [int];
  logic [63:0] last_rd = '0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          words [5] = '{0, 1, 2, 3, 4095};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] tb_merge(input logic [63:0] o, input logic [63:0] n,
                                           input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int k = 0; k < 8; k++) if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] waddr(input int w);
    return BASE + (64'(w) << 3);
  endfunction

  // Drive one request cycle and record what the DUT must answer with.
  task automatic drive(input logic en, input logic [7:0] we, input logic [63:0] addr,
                       input logic [63:0] wd);
    logic inr;
    int   wi;
    exp_t e;
    @(posedge clk);
    #1;
    data_sram_en    = en;
    data_sram_we    = en ? we : 8'h00;
    data_sram_addr  = en ? addr : 64'h0;
    data_sram_wdata = en ? wd : 64'h0;
    if (en) begin
      inr = (addr >= BASE) && (addr < LIM);
      wi  = int'((addr - BASE) >> 3);
      if (we == 8'h00) begin
        e.is_ld = 1'b1;
        e.err   = !inr;
        e.dat   = (inr && model.exists(wi)) ? model[wi] : 64'h0;
        sb_q.push_back(e);
      end else if (!inr) begin
        e.is_ld = 1'b0;
        e.err   = 1'b1;
        e.dat   = 64'h0;
        sb_q.push_back(e);
      end else begin
        model[wi] = tb_merge(model.exists(wi) ? model[wi] : 64'h0, wd, we);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 64'h0, 64'h0);
  endtask

  // Response monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_rd = '0;
    end else if (data_sram_rvalid || addr_err) begin
      if (sb_q.size() == 0) begin
        chk("sb_spurious", {62'h0, data_sram_rvalid, addr_err}, 64'h0);
      end else begin
        e = sb_q.pop_front();
        chk("rvalid", 64'(data_sram_rvalid), 64'(e.is_ld));
        chk("addr_err", 64'(addr_err), 64'(e.err));
        if (e.is_ld) begin
          chk("rdata", data_sram_rdata, e.dat);
          last_rd = e.dat;
        end else begin
          chk("rdata_hold_oor_st", data_sram_rdata, last_rd);
        end
      end
    end else begin
      chk("rdata_hold", data_sram_rdata, last_rd);
    end
  end

  initial begin
    logic [63:0] saved;
    int          w, op;
    logic [7:0]  we;

    #12;
    chk("rst_rdata", data_sram_rdata, 64'h0);
    chk("rst_rvalid", 64'(data_sram_rvalid), 64'h0);
    chk("rst_addr_err", 64'(addr_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload through full-word stores, then drain.
    drive(1'b1, 8'hFF, waddr(0), 64'h1111_2222_3333_4444);
    drive(1'b1, 8'hFF, waddr(1), 64'h0);
    drive(1'b1, 8'hFF, waddr(2), 64'h0123_4567_89AB_CDEF);
    drive(1'b1, 8'hFF, waddr(3), 64'hFEDC_BA98_7654_3210);
    drive(1'b1, 8'hFF, waddr(4095), 64'h5A5A_A5A5_0F0F_F0F0);
    idle(2);

    // Plain load.
    drive(1'b1, 8'h00, waddr(0), 64'h0);
    idle(1);
    // Partial store then immediate load (bypass).
    drive(1'b1, 8'h0F, waddr(1), 64'hAAAA_BBBB_CCCC_DDDD);
    drive(1'b1, 8'h00, waddr(1), 64'h0);
    idle(2);
    // Two merges to one word, drain, load.
    drive(1'b1, 8'h01, waddr(2), 64'h0000_0000_0000_00EE);
    drive(1'b1, 8'h80, waddr(2), 64'hEE00_0000_0000_0000);
    idle(1);
    drive(1'b1, 8'h00, waddr(2), 64'h0);
    // Eviction by a store to another word.
    drive(1'b1, 8'hFF, waddr(2), 64'hA0A0_A0A0_A0A0_A0A0);
    drive(1'b1, 8'hFF, waddr(3), 64'hB0B0_B0B0_B0B0_B0B0);
    drive(1'b1, 8'h00, waddr(2), 64'h0);
    idle(1);
    drive(1'b1, 8'h00, waddr(3), 64'h0);
    // Out-of-range loads and store; top word in range.
    drive(1'b1, 8'h00, 64'h7FFF_FFF8, 64'h0);
    drive(1'b1, 8'h00, 64'h8000_8000, 64'h0);
    drive(1'b1, 8'hFF, 64'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF);
    drive(1'b1, 8'h00, waddr(4095), 64'h0);
    drive(1'b1, 8'h00, waddr(0), 64'h0);
    idle(2);

    // Pending store dropped by reset.
    drive(1'b1, 8'h00, waddr(0), 64'h0);
    saved = model[3];
    drive(1'b1, 8'hFF, waddr(3), 64'hC3C3_C3C3_C3C3_C3C3);
    @(posedge clk);
    #2;
    data_sram_en = 1'b0;
    data_sram_we = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", data_sram_rdata, 64'h0);
    chk("mid_rst_rvalid", 64'(data_sram_rvalid), 64'h0);
    chk("mid_rst_addr_err", 64'(addr_err), 64'h0);
    chk("sb_at_reset", 64'(sb_q.size()), 64'h0);
    model[3] = saved;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h00, waddr(3), 64'h0);
    idle(1);

    // Random mix over the preloaded words.
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      w  = words[$urandom_range(0, 4)];
      we = 8'($urandom_range(1, 255));
      if (op <= 3)
        drive(1'b1, 8'h00, waddr(w) + 64'($urandom_range(0, 7)), 64'h0);
      else if (op <= 6)
        drive(1'b1, we, waddr(w), {$urandom, $urandom});
      else if (op <= 8)
        idle(1);
      else if (op[0])
        drive(1'b1, 8'h00, LIM + 64'({$urandom_range(0, 15), 3'b000}), 64'h0);
      else
        drive(1'b1, we, 64'h7FFF_FFF8, {$urandom, $urandom});
    end

    idle(3);
    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
